// File: rtl/pkt_mem_pkg.sv
// pkt_mem_pkg
//   Shared definitions for the packet-buffer arbiter: default data and
//   address widths, the arbiter state encoding and the owner tag used for
//   the round-robin history and for tagging in-flight reads.
package pkt_mem_pkg;

  localparam int DWIDTH_DEFAULT    = 72;
  localparam int AWIDTH_DEFAULT    = 10;
  localparam int MAX_BURST_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_OWN_CPU = 2'b01,
    ST_OWN_ACC = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_ACC = 1'b1
  } owner_e;

endpackage

// File: rtl/pkt_mem_arbiter_rr_pick2.sv
// rr_pick2
//   Two-input round-robin tie-break. A lone requester always wins; when
//   both request, the one that did not own the buffer last wins.
//
//   cpu_req_i     processor request
//   acc_req_i     accelerator request
//   last_owner_i  requester that held the buffer most recently
//   pick_cpu_o    processor selected (one-hot with pick_acc_o)
//   pick_acc_o    accelerator selected
module rr_pick2
  import pkt_mem_pkg::*;
(
  input  logic   cpu_req_i,
  input  logic   acc_req_i,
  input  owner_e last_owner_i,
  output logic   pick_cpu_o,
  output logic   pick_acc_o
);

  assign pick_cpu_o = cpu_req_i && (!acc_req_i || (last_owner_i == OWNER_ACC));
  assign pick_acc_o = acc_req_i && (!cpu_req_i || (last_owner_i == OWNER_CPU));

endmodule

// File: rtl/pkt_mem_arbiter.sv
// pkt_mem_arbiter
//   Arbitrates a single-port packet buffer between a processor (cpu) and an
//   accelerator (acc). Ownership is granted one cycle after a request is
//   seen, handed over without an idle bubble, and forcibly rotated after
//   MAX_BURST owned cycles when the other side is waiting. Reads issued by
//   the owner are tracked so that read-valid returns to the issuing side
//   one cycle later even if ownership has moved on.
//
//   clk, reset_n              clock, asynchronous active-low reset
//   cpu_req/acc_req           ownership requests
//   cpu_we/acc_we             write strobes (honoured only while granted)
//   cpu_addr/acc_addr         word addresses
//   cpu_din/acc_din           write data
//   cpu_gnt/acc_gnt           registered grants (never both high)
//   cpu_rdata/acc_rdata       read data, both straight from mem_dout
//   cpu_rvalid/acc_rvalid     read data valid for the issuing requester
//   mem_we/mem_addr/mem_din   buffer port, muxed from the owner
//   mem_dout                  buffer read data, one cycle after address
module pkt_mem_arbiter
  import pkt_mem_pkg::*;
#(
  parameter int DWIDTH    = DWIDTH_DEFAULT,
  parameter int AWIDTH    = AWIDTH_DEFAULT,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AWIDTH-1:0] cpu_addr,
  input  logic [DWIDTH-1:0] cpu_din,
  output logic              cpu_gnt,
  output logic [DWIDTH-1:0] cpu_rdata,
  output logic              cpu_rvalid,

  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [AWIDTH-1:0] acc_addr,
  input  logic [DWIDTH-1:0] acc_din,
  output logic              acc_gnt,
  output logic [DWIDTH-1:0] acc_rdata,
  output logic              acc_rvalid,

  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  input  logic [DWIDTH-1:0] mem_dout
);

  // One extra bit so the counter can hold MAX_BURST itself and saturate there.
  localparam int                CNT_W       = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0]  BURST_LIMIT = CNT_W'(MAX_BURST);

  arb_state_e       state_q, state_d;
  owner_e           last_owner_q, last_owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0] burst_inc;
  logic             burst_done;
  logic             cpu_gnt_q, acc_gnt_q;
  logic             rd_pend_q;
  owner_e           rd_tag_q;
  logic             pick_cpu, pick_acc;

  rr_pick2 u_rr_pick2 (
    .cpu_req_i    (cpu_req),
    .acc_req_i    (acc_req),
    .last_owner_i (last_owner_q),
    .pick_cpu_o   (pick_cpu),
    .pick_acc_o   (pick_acc)
  );

  // Next-state logic. burst_cnt_q holds the number of owned cycles already
  // completed, so burst_inc is the count including the current cycle; the
  // counter clears on every ownership change and while idle.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = '0;
    burst_inc    = (burst_cnt_q == BURST_LIMIT) ? burst_cnt_q : burst_cnt_q + CNT_W'(1);
    burst_done   = (burst_inc == BURST_LIMIT);

    case (state_q)
      ST_IDLE: begin
        if (pick_cpu) begin
          state_d      = ST_OWN_CPU;
          last_owner_d = OWNER_CPU;
        end else if (pick_acc) begin
          state_d      = ST_OWN_ACC;
          last_owner_d = OWNER_ACC;
        end
      end
      ST_OWN_CPU: begin
        // A waiting accelerator takes over when the cpu lets go or its burst is used up.
        if (acc_req && (!cpu_req || burst_done)) begin
          state_d      = ST_OWN_ACC;
          last_owner_d = OWNER_ACC;
        end else if (!cpu_req) begin
          state_d = ST_IDLE;
        end else begin
          burst_cnt_d = burst_inc;
        end
      end
      ST_OWN_ACC: begin
        if (cpu_req && (!acc_req || burst_done)) begin
          state_d      = ST_OWN_CPU;
          last_owner_d = OWNER_CPU;
        end else if (!acc_req) begin
          state_d = ST_IDLE;
        end else begin
          burst_cnt_d = burst_inc;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs. The grants are registered copies of the
  // next state; the read-pending flag and tag capture every granted cycle
  // without a write strobe so rvalid lands one cycle later on the issuer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_ACC;
      burst_cnt_q  <= '0;
      cpu_gnt_q    <= 1'b0;
      acc_gnt_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_tag_q     <= OWNER_CPU;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      cpu_gnt_q    <= (state_d == ST_OWN_CPU);
      acc_gnt_q    <= (state_d == ST_OWN_ACC);
      rd_pend_q    <= (cpu_gnt_q && !cpu_we) || (acc_gnt_q && !acc_we);
      rd_tag_q     <= acc_gnt_q ? OWNER_ACC : OWNER_CPU;
    end
  end

  // Buffer port follows the current grant; with no owner everything is
  // driven to zero, which also blocks strobes from ungranted requesters.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (cpu_gnt_q) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_din  = cpu_din;
    end else if (acc_gnt_q) begin
      mem_we   = acc_we;
      mem_addr = acc_addr;
      mem_din  = acc_din;
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign acc_gnt    = acc_gnt_q;
  assign cpu_rvalid = rd_pend_q && (rd_tag_q == OWNER_CPU);
  assign acc_rvalid = rd_pend_q && (rd_tag_q == OWNER_ACC);
  assign cpu_rdata  = mem_dout;
  assign acc_rdata  = mem_dout;

endmodule

// File: tb/tb_pkt_mem_arbiter.sv
// tb_pkt_mem_arbiter
//   Self-checking bench for pkt_mem_arbiter. A behavioural single-port
//   memory sits on the buffer port; the bench keeps its own shadow copy of
//   the expected contents and a queue of expected read returns.
module tb_pkt_mem_arbiter;

  localparam int DW        = 72;
  localparam int AW        = 10;
  localparam int MB        = 16;
  localparam int MEM_WORDS = 1 << AW;
  localparam int NV        = 26;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we, acc_req, acc_we;
  logic [AW-1:0] cpu_addr, acc_addr;
  logic [DW-1:0] cpu_din, acc_din;
  logic          cpu_gnt, acc_gnt, cpu_rvalid, acc_rvalid;
  logic [DW-1:0] cpu_rdata, acc_rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  typedef struct {
    logic          cR;
    logic          cW;
    logic [AW-1:0] cA;
    logic          aR;
    logic          aW;
    logic [AW-1:0] aA;
    logic          eC;
    logic          eA;
  } vec_t;

  typedef struct {
    logic          isAcc;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  vec_t          vecs [NV];
  rd_exp_t       sbQueue [$];
  logic [DW-1:0] shadow [MEM_WORDS];
  logic [DW-1:0] memArr [MEM_WORDS];
  logic          memFilled = 1'b0;
  logic          expCpuGnt, expAccGnt;
  int            cycleCnt;
  int            checks;
  int            errors;

  pkt_mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_gnt    (cpu_gnt),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .acc_req    (acc_req),
    .acc_we     (acc_we),
    .acc_addr   (acc_addr),
    .acc_din    (acc_din),
    .acc_gnt    (acc_gnt),
    .acc_rdata  (acc_rdata),
    .acc_rvalid (acc_rvalid),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] memPattern(input int idx);
    return {8'h5A, 32'(idx) * 32'h0000_9E37, 32'(idx) ^ 32'hFFFF_0000};
  endfunction

  // Behavioural buffer: preloaded with a known pattern on the first edge,
  // then one write port and a registered read with one-cycle latency.
  always @(posedge clk) begin
    if (!memFilled) begin
      for (int i = 0; i < MEM_WORDS; i++) memArr[i] <= memPattern(i);
      memFilled <= 1'b1;
    end else if (mem_we) begin
      memArr[mem_addr] <= mem_din;
    end
    mem_dout <= memArr[mem_addr];
  end

  // Watchdog so a stuck run still ends with a visible report.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] simulation timeout");
  end

  function automatic vec_t mkVec(input logic cR, input logic cW, input logic [AW-1:0] cA,
                                 input logic aR, input logic aW, input logic [AW-1:0] aA,
                                 input logic eC, input logic eA);
    vec_t v;
    v.cR = cR; v.cW = cW; v.cA = cA;
    v.aR = aR; v.aW = aW; v.aA = aA;
    v.eC = eC; v.eA = eA;
    return v;
  endfunction

  task automatic checkEq(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Drive one cycle of stimulus and record what the bench expects from it:
  // granted writes update the shadow, granted reads queue an expected return.
  task automatic applyStimulus(input logic cR, input logic cW, input logic [AW-1:0] cA,
                               input logic aR, input logic aW, input logic [AW-1:0] aA,
                               input logic eC, input logic eA);
    rd_exp_t e;
    cycleCnt++;
    cpu_req   = cR;
    cpu_we    = cW;
    cpu_addr  = cA;
    cpu_din   = {8'hC5, 32'(cycleCnt), 32'h1234_5678};
    acc_req   = aR;
    acc_we    = aW;
    acc_addr  = aA;
    acc_din   = {8'hAC, 32'(cycleCnt), 32'h8765_4321};
    expCpuGnt = eC;
    expAccGnt = eA;
    if (eC) begin
      if (cW) shadow[cA] = cpu_din;
      else begin
        e.isAcc = 1'b0; e.data = shadow[cA]; e.due = cycleCnt + 1;
        sbQueue.push_back(e);
      end
    end else if (eA) begin
      if (aW) shadow[aA] = acc_din;
      else begin
        e.isAcc = 1'b1; e.data = shadow[aA]; e.due = cycleCnt + 1;
        sbQueue.push_back(e);
      end
    end
  endtask

  // Sample on the falling edge and compare grants, buffer port and returns.
  task automatic checkOutput();
    rd_exp_t       e;
    logic          expWe, expCpuRv, expAccRv;
    logic [DW-1:0] expAddr, expDin, expData;
    @(negedge clk);
    expWe    = 1'b0;
    expAddr  = '0;
    expDin   = '0;
    expCpuRv = 1'b0;
    expAccRv = 1'b0;
    expData  = '0;
    if (expCpuGnt) begin
      expWe = cpu_we; expAddr = DW'(cpu_addr); expDin = cpu_din;
    end else if (expAccGnt) begin
      expWe = acc_we; expAddr = DW'(acc_addr); expDin = acc_din;
    end
    if (sbQueue.size() > 0 && sbQueue[0].due == cycleCnt) begin
      e = sbQueue.pop_front();
      expCpuRv = !e.isAcc;
      expAccRv = e.isAcc;
      expData  = e.data;
    end
    checkEq("cpu_gnt", DW'(cpu_gnt), DW'(expCpuGnt));
    checkEq("acc_gnt", DW'(acc_gnt), DW'(expAccGnt));
    checkEq("gnt_overlap", DW'(cpu_gnt & acc_gnt), '0);
    checkEq("mem_we", DW'(mem_we), DW'(expWe));
    checkEq("mem_addr", DW'(mem_addr), expAddr);
    checkEq("mem_din", mem_din, expDin);
    checkEq("cpu_rvalid", DW'(cpu_rvalid), DW'(expCpuRv));
    checkEq("acc_rvalid", DW'(acc_rvalid), DW'(expAccRv));
    if (expCpuRv) checkEq("cpu_rdata", cpu_rdata, expData);
    if (expAccRv) checkEq("acc_rdata", acc_rdata, expData);
  endtask

  task automatic runCycle(input logic cR, input logic cW, input logic [AW-1:0] cA,
                          input logic aR, input logic aW, input logic [AW-1:0] aA,
                          input logic eC, input logic eA);
    @(posedge clk);
    #1;
    applyStimulus(cR, cW, cA, aR, aW, aA, eC, eA);
    checkOutput();
  endtask

  // Main sequence: reset state, vector table, forced burst rotation,
  // saturation with a late competitor, and reset during a pending read.
  initial begin
    logic eC, eA, hold, cR, aR;

    // cpu: req we addr | acc: req we addr | expected cpu_gnt acc_gnt
    vecs[0]  = mkVec(1'b1, 1'b0, 10'h005, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    vecs[1]  = mkVec(1'b1, 1'b0, 10'h005, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
    vecs[2]  = mkVec(1'b1, 1'b1, 10'h010, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
    vecs[3]  = mkVec(1'b1, 1'b0, 10'h010, 1'b1, 1'b1, 10'h025, 1'b1, 1'b0);
    vecs[4]  = mkVec(1'b0, 1'b0, 10'h011, 1'b1, 1'b1, 10'h020, 1'b1, 1'b0);
    vecs[5]  = mkVec(1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h020, 1'b0, 1'b1);
    vecs[6]  = mkVec(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h020, 1'b0, 1'b1);
    vecs[7]  = mkVec(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h021, 1'b0, 1'b1);
    vecs[8]  = mkVec(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    vecs[9]  = mkVec(1'b0, 1'b1, 10'h030, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    vecs[10] = mkVec(1'b1, 1'b0, 10'h3FF, 1'b1, 1'b0, 10'h001, 1'b0, 1'b0);
    vecs[11] = mkVec(1'b1, 1'b0, 10'h3FF, 1'b1, 1'b0, 10'h001, 1'b1, 1'b0);
    vecs[12] = mkVec(1'b0, 1'b1, 10'h040, 1'b1, 1'b0, 10'h001, 1'b1, 1'b0);
    vecs[13] = mkVec(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h025, 1'b0, 1'b1);
    vecs[14] = mkVec(1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 10'h002, 1'b0, 1'b1);
    vecs[15] = mkVec(1'b1, 1'b0, 10'h040, 1'b1, 1'b0, 10'h002, 1'b0, 1'b0);
    vecs[16] = mkVec(1'b1, 1'b0, 10'h040, 1'b1, 1'b0, 10'h002, 1'b1, 1'b0);
    vecs[17] = mkVec(1'b0, 1'b1, 10'h050, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
    vecs[18] = mkVec(1'b1, 1'b0, 10'h006, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    vecs[19] = mkVec(1'b0, 1'b0, 10'h006, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
    vecs[20] = mkVec(1'b1, 1'b0, 10'h007, 1'b1, 1'b0, 10'h008, 1'b0, 1'b0);
    vecs[21] = mkVec(1'b1, 1'b0, 10'h007, 1'b1, 1'b0, 10'h008, 1'b0, 1'b1);
    vecs[22] = mkVec(1'b1, 1'b0, 10'h007, 1'b0, 1'b0, 10'h009, 1'b0, 1'b1);
    vecs[23] = mkVec(1'b0, 1'b0, 10'h030, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
    vecs[24] = mkVec(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    vecs[25] = mkVec(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);

    for (int i = 0; i < MEM_WORDS; i++) shadow[i] = memPattern(i);
    cycleCnt  = 0;
    checks    = 0;
    errors    = 0;
    expCpuGnt = 1'b0;
    expAccGnt = 1'b0;
    reset_n   = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    acc_req = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_din = '0;
    $display("[TB] pkt_mem_arbiter bench starting");

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkEq("rst_cpu_gnt", DW'(cpu_gnt), '0);
    checkEq("rst_acc_gnt", DW'(acc_gnt), '0);
    checkEq("rst_cpu_rvalid", DW'(cpu_rvalid), '0);
    checkEq("rst_acc_rvalid", DW'(acc_rvalid), '0);
    checkEq("rst_mem_we", DW'(mem_we), '0);
    checkEq("rst_mem_addr", DW'(mem_addr), '0);
    checkEq("rst_mem_din", mem_din, '0);

    // Vector table; reset releases at the start of row 0
    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) reset_n = 1'b1;
      applyStimulus(vecs[i].cR, vecs[i].cW, vecs[i].cA, vecs[i].aR, vecs[i].aW, vecs[i].aA,
                    vecs[i].eC, vecs[i].eA);
      checkOutput();
    end

    // Both requesting continuously: acc (cpu owned last) first, rotating every MB cycles
    for (int k = 0; k < 73; k++) begin
      hold = (k < 70);
      if (k == 0 || k > 70) begin
        eC = 1'b0; eA = 1'b0;
      end else begin
        eA = ((((k - 1) / MB) % 2) == 0);
        eC = !eA;
      end
      runCycle(hold, 1'b0, 10'h3FF, hold, 1'b0, AW'(k), eC, eA);
    end

    // cpu alone past the burst limit keeps ownership; a late acc request takes over next cycle
    for (int k = 0; k < 26; k++) begin
      cR = (k <= 21);
      aR = (k >= 21 && k <= 22);
      eC = (k >= 1 && k <= 21);
      eA = (k == 22 || k == 23);
      runCycle(cR, k[0], 10'h100 + AW'(k), aR, 1'b0, 10'h200 + AW'(k), eC, eA);
    end

    // Reset asserted while a read is pending and a write is on the port
    runCycle(1'b1, 1'b0, 10'h070, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    runCycle(1'b1, 1'b0, 10'h070, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    cpu_we   = 1'b1;
    cpu_addr = 10'h071;
    #2;
    reset_n = 1'b0;
    #1;
    checkEq("mid_rst_cpu_gnt", DW'(cpu_gnt), '0);
    checkEq("mid_rst_acc_gnt", DW'(acc_gnt), '0);
    checkEq("mid_rst_cpu_rvalid", DW'(cpu_rvalid), '0);
    checkEq("mid_rst_acc_rvalid", DW'(acc_rvalid), '0);
    checkEq("mid_rst_mem_we", DW'(mem_we), '0);
    sbQueue.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEq("rst_hold_cpu_gnt", DW'(cpu_gnt), '0);
    checkEq("rst_hold_cpu_rvalid", DW'(cpu_rvalid), '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 10'h072, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    checkOutput();
    runCycle(1'b1, 1'b1, 10'h072, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
    runCycle(1'b1, 1'b0, 10'h072, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
    runCycle(1'b0, 1'b1, 10'h073, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0);
    runCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);
    runCycle(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 1'b0, 1'b0);

    checkEq("sb_drained", DW'(sbQueue.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pkt_mem_arbiter.md
PKT_MEM_ARBITER -- requirements
Module: pkt_mem_arbiter

Interface
REQ-001 Parameter DWIDTH, default 72, SHALL set the packet-buffer data width.
REQ-002 Parameter AWIDTH, default 10, SHALL set the packet-buffer word-address width.
REQ-003 Parameter MAX_BURST, default 16, SHALL set the maximum consecutive grant cycles while the other requester waits.
REQ-004 Clock and reset: one clock, clk; reset is asynchronous and active-low, named reset_n; no other clock or reset ports.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 cpu_req / acc_req  input  1 each  processor / accelerator requests buffer ownership.
REQ-008 cpu_we / acc_we  input  1 each  write strobe, valid only while that requester is granted.
REQ-009 cpu_addr / acc_addr  input  AWIDTH each  word address.
REQ-010 cpu_din / acc_din  input  DWIDTH each  write data.
REQ-011 cpu_gnt / acc_gnt  output  1 each  registered ownership grant.
REQ-012 cpu_rdata / acc_rdata  output  DWIDTH each  read data, both driven from mem_dout.
REQ-013 cpu_rvalid / acc_rvalid  output  1 each  read-data-valid strobe.
REQ-014 mem_we  output  1; mem_addr  output  AWIDTH; mem_din  output  DWIDTH  buffer port to memory.
REQ-015 mem_dout  input  DWIDTH  memory read data, one-cycle latency after address.

Function
REQ-016 States SHALL be IDLE, OWN_CPU, OWN_ACC; at most one gnt high in any cycle.
REQ-017 IDLE: cpu_req only -> OWN_CPU; acc_req only -> OWN_ACC; both -> requester not served last (last_owner register, reset value ACC, so CPU wins first tie).
REQ-018 Grant SHALL assert the cycle after entering OWN_x, i.e. one cycle after req sampled high in IDLE; no combinational req-to-gnt path.
REQ-019 OWN_x: owner deasserts req -> owner's gnt falls next cycle; next state OWN_other if other req high, else IDLE; no idle bubble on handover.
REQ-020 Burst counter SHALL count owner cycles from 1; when it reaches MAX_BURST and other req is high, ownership SHALL transfer next cycle regardless of owner req; if other req low, counter saturates and owner keeps grant.
REQ-021 Counter SHALL reset to 0 on every ownership change and in IDLE; width clog2(MAX_BURST)+1.
REQ-022 mem_addr/mem_din/mem_we SHALL be a combinational mux of the granted requester's inputs; mem_we = we & gnt of owner; in IDLE mem_we=0, mem_addr=0, mem_din=0.
REQ-023 Every granted cycle with we=0 is a read; a 1-bit read-pending flag plus owner tag SHALL register it, producing x_rvalid exactly one cycle later for the issuing requester only, even if ownership changed in between.
REQ-024 Writes SHALL never produce rvalid; rvalid for both requesters SHALL never be high together.
REQ-025 we asserted without gnt SHALL be ignored (no memory write, no error).

Reset
REQ-026 On reset_n low: state=IDLE, last_owner=ACC, counter=0, both gnt=0, both rvalid=0, read-pending cleared, mem_we=0 immediately (asynchronous).
REQ-027 Reset mid-read SHALL suppress that read's rvalid; first grant after release earliest one cycle after reset_n rises with req high.

Structure
REQ-028 State encodings (IDLE=2'b00, OWN_CPU=2'b01, OWN_ACC=2'b10) and owner tag constants SHALL live in a shared package pkt_mem_pkg; DWIDTH/AWIDTH defaults also defined there.
REQ-029 One sub-module, rr_pick2, SHALL implement the two-input round-robin tie-break from last_owner; rest stays flat; target 120-400 RTL lines.

Verification
REQ-030 Reset release, cpu_req high cycle 0 -> cpu_gnt=1 cycle 1; read addr 0x005 -> cpu_rvalid=1 cycle 2 with mem_dout data; acc_rvalid=0.
REQ-031 cpu_req and acc_req both high from IDLE after reset -> cpu_gnt first; cpu drops after 3 cycles -> acc_gnt next cycle, no IDLE cycle.
REQ-032 Both req held high continuously, MAX_BURST=16 -> grants alternate every 16 cycles, never overlap.
REQ-033 CPU reads addr 0x3FF in its last owned cycle, ACC granted next -> cpu_rvalid=1 in ACC's first cycle, acc_rvalid=0.
REQ-034 acc_we=1, acc_req=0 while CPU owns -> mem_we follows cpu_we only; buffer contents at acc_addr unchanged.
REQ-035 reset_n low during a pending read -> gnt, rvalid, mem_we all 0 same cycle; no rvalid after release until a new read issues.
